// File: rtl/fpu_iter_sequencer_if.sv
// rtl/fpu_iter_sequencer_if.sv - request/grant, stall and iteration status bundle for fpu_iter_sequencer
interface fpu_iter_sequencer_if;
  logic       div_req;
  logic       sqrt_req;
  logic       div_gnt;
  logic       sqrt_gnt;
  logic       hold;
  logic       abort;
  logic       step;
  logic       first;
  logic       last;
  logic [5:0] count;
  logic       owner;
  logic       busy;
  logic       done;

  modport master (
    output div_req, sqrt_req, hold, abort,
    input  div_gnt, sqrt_gnt, step, first, last, count, owner, busy, done
  );

  modport slave (
    input  div_req, sqrt_req, hold, abort,
    output div_gnt, sqrt_gnt, step, first, last, count, owner, busy, done
  );
endinterface

// File: rtl/fpu_iter_sequencer.sv
// rtl/fpu_iter_sequencer.sv - round-robin sequencer sharing one iteration datapath between divide and sqrt
// Optional abort support is enabled by defining FPU_SEQ_ABORT_EN.
module fpu_iter_sequencer #(
  parameter int unsigned DIV_ITER  = 27,
  parameter int unsigned SQRT_ITER = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  fpu_iter_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  localparam logic [5:0] DIV_LOAD  = 6'(DIV_ITER - 1);
  localparam logic [5:0] SQRT_LOAD = 6'(SQRT_ITER - 1);

  logic       rst_meta_q;
  logic       rst_q;

  state_t     state_q, state_d;
  logic [5:0] count_q, count_d;
  logic       owner_q, owner_d;
  logic       rr_q, rr_d;
  logic       first_pend_q, first_pend_d;
  logic       div_gnt_q, div_gnt_d;
  logic       sqrt_gnt_q, sqrt_gnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       step_w;
  logic       abort_w;

  // Assert immediately, release two clocks after reset falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

`ifdef FPU_SEQ_ABORT_EN
  assign abort_w = bus.abort;
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_w      = 1'b0;
`endif

  assign step_w = (state_q == RUN) && !bus.hold;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    owner_d      = owner_q;
    rr_d         = rr_q;
    first_pend_d = first_pend_q;
    unique case (state_q)
      IDLE: begin
        if (bus.div_req || bus.sqrt_req) begin
          state_d = LOAD;
          // rr_q names the requester to favour on a tie.
          owner_d = (bus.div_req && bus.sqrt_req) ? rr_q : bus.sqrt_req;
          rr_d    = ~owner_d;
        end
      end
      LOAD: begin
        state_d      = RUN;
        count_d      = owner_q ? SQRT_LOAD : DIV_LOAD;
        first_pend_d = 1'b1;
      end
      RUN: begin
        if (step_w) begin
          first_pend_d = 1'b0;
          if (count_q == '0) state_d = DONE;
          else               count_d = count_q - 6'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_w && ((state_q == LOAD) || (state_q == RUN))) begin
      state_d      = IDLE;
      count_d      = '0;
      first_pend_d = 1'b0;
    end
  end

  always_comb begin
    busy_d     = (state_d != IDLE);
    div_gnt_d  = busy_d && !owner_d;
    sqrt_gnt_d = busy_d && owner_d;
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst_q) begin
    if (rst_q) begin
      state_q      <= IDLE;
      count_q      <= '0;
      owner_q      <= 1'b0;
      rr_q         <= 1'b0;
      first_pend_q <= 1'b0;
      div_gnt_q    <= 1'b0;
      sqrt_gnt_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      owner_q      <= owner_d;
      rr_q         <= rr_d;
      first_pend_q <= first_pend_d;
      div_gnt_q    <= div_gnt_d;
      sqrt_gnt_q   <= sqrt_gnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.div_gnt  = div_gnt_q;
  assign bus.sqrt_gnt = sqrt_gnt_q;
  assign bus.step     = step_w;
  assign bus.first    = step_w && first_pend_q;
  assign bus.last     = step_w && (count_q == '0);
  assign bus.count    = count_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_fpu_iter_sequencer.sv
// tb/tb_fpu_iter_sequencer.sv - directed self-checking bench for fpu_iter_sequencer
module tb_fpu_iter_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  fpu_iter_sequencer_if bus ();
  fpu_iter_sequencer_if bus1 ();

  fpu_iter_sequencer #(.DIV_ITER(27), .SQRT_ITER(26)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fpu_iter_sequencer #(.DIV_ITER(2), .SQRT_ITER(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller raises the request(s); first tick lands in LOAD.
  task automatic run_op(input string tag, input logic exp_owner, input int iter,
                        input int hold_at, input int hold_len, input bit drop_req);
    int gnt_cyc   = 0;
    int other_gnt = 0;
    int steps     = 0;
    int firsts    = 0;
    int lasts     = 0;
    int first_idx = -1;
    int last_idx  = -1;
    int cnt_bad   = 0;
    int held_step = 0;
    int held_bad  = 0;
    int done_at   = 0;
    int hold_left = 0;
    int exp_cnt   = iter - 1;
    bit hold_done = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k == 1) begin
        check({tag, " owner"}, bus.owner, exp_owner);
        if (drop_req) begin
          bus.div_req  = 1'b0;
          bus.sqrt_req = 1'b0;
        end
      end
      if (!hold_done && hold_len > 0 && k >= 2 && bus.count == 6'(hold_at)) begin
        hold_left = hold_len;
        hold_done = 1'b1;
      end
      bus.hold = (hold_left > 0);
      #1;
      if (bus.hold) begin
        hold_left--;
        if (bus.step) held_step++;
        if (bus.count != 6'(hold_at)) held_bad++;
      end
      if (exp_owner ? bus.sqrt_gnt : bus.div_gnt) gnt_cyc++;
      if (exp_owner ? bus.div_gnt : bus.sqrt_gnt) other_gnt++;
      if (bus.step) begin
        if (bus.count != 6'(exp_cnt)) cnt_bad++;
        if (bus.first) begin firsts++; first_idx = steps; end
        if (bus.last)  begin lasts++;  last_idx  = steps; end
        exp_cnt--;
        steps++;
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
    end
    bus.hold = 1'b0;
    check({tag, " done_at"},   done_at, iter + 2 + hold_len);
    check({tag, " steps"},     steps, iter);
    check({tag, " gnt_cyc"},   gnt_cyc, iter + 2 + hold_len);
    check({tag, " other_gnt"}, other_gnt, 0);
    check({tag, " count_seq"}, cnt_bad, 0);
    check({tag, " firsts"},    firsts, 1);
    check({tag, " first_idx"}, first_idx, 0);
    check({tag, " lasts"},     lasts, 1);
    check({tag, " last_idx"},  last_idx, iter - 1);
    if (hold_len > 0) begin
      check({tag, " held_step"},  held_step, 0);
      check({tag, " held_count"}, held_bad, 0);
    end
  endtask

  task automatic idle_gap(input string tag);
    tick();
    check({tag, " gap busy"},  bus.busy, 0);
    check({tag, " gap done"},  bus.done, 0);
    check({tag, " gap gnt"},   {bus.div_gnt, bus.sqrt_gnt}, 0);
    check({tag, " gap count"}, bus.count, 0);
    check({tag, " gap step"},  bus.step, 0);
  endtask

  initial begin
    int k;
    int kk;
    int dn;
    errors = 0;
    checks = 0;
    clk = 1'b0;
    reset = 1'b0;
    bus.div_req = 1'b0;  bus.sqrt_req = 1'b0;  bus.hold = 1'b0;  bus.abort = 1'b0;
    bus1.div_req = 1'b0; bus1.sqrt_req = 1'b0; bus1.hold = 1'b0; bus1.abort = 1'b0;

    #2 reset = 1'b1;
    #1;
    check("rst busy",  bus.busy, 0);
    check("rst gnt",   {bus.div_gnt, bus.sqrt_gnt}, 0);
    check("rst strb",  {bus.step, bus.first, bus.last, bus.done}, 0);
    check("rst count", bus.count, 0);
    check("rst owner", bus.owner, 0);
    check("rst busy1", bus1.busy, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (3) tick();

    // single divide, request dropped after grant
    bus.div_req = 1'b1;
    run_op("div1", 1'b0, 27, -1, 0, 1'b1);
    idle_gap("div1");

    // sqrt with a 3-cycle stall at count 10
    bus.sqrt_req = 1'b1;
    run_op("sqrt_hold", 1'b1, 26, 10, 3, 1'b1);
    idle_gap("sqrt_hold");

    // abort at count 12
    bus.div_req = 1'b1;
    tick();
    check("abort load gnt", bus.div_gnt, 1);
    bus.div_req = 1'b0;
    for (k = 2; k < 60; k++) begin
      tick();
      if (bus.count == 6'd12) break;
    end
    check("abort reach12", k, 16);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
`ifdef FPU_SEQ_ABORT_EN
    check("abort busy",  bus.busy, 0);
    check("abort count", bus.count, 0);
    check("abort gnt",   bus.div_gnt, 0);
    check("abort done",  bus.done, 0);
    dn = 0;
    repeat (40) begin
      tick();
      if (bus.done) dn++;
    end
    check("abort no_done", dn, 0);
`else
    check("noabort busy",  bus.busy, 1);
    check("noabort count", bus.count, 11);
    kk = k + 1;
    while (!bus.done && kk < 80) begin
      tick();
      kk++;
    end
    check("noabort done_at", kk, 29);
    idle_gap("noabort");
`endif

    // reset at count 5 during a divide
    bus.div_req = 1'b1;
    tick();
    bus.div_req = 1'b0;
    for (k = 2; k < 60; k++) begin
      tick();
      if (bus.count == 6'd5) break;
    end
    check("midrst reach5", k, 23);
    #2 reset = 1'b1;
    #1;
    check("midrst busy",  bus.busy, 0);
    check("midrst gnt",   {bus.div_gnt, bus.sqrt_gnt}, 0);
    check("midrst strb",  {bus.step, bus.first, bus.last, bus.done}, 0);
    check("midrst count", bus.count, 0);
    check("midrst owner", bus.owner, 0);
    dn = 0;
    repeat (3) begin
      tick();
      if (bus.done) dn++;
    end
    check("midrst no_done", dn, 0);
    reset = 1'b0;
    repeat (3) tick();

    // both requests held: div, sqrt, div
    bus.div_req  = 1'b1;
    bus.sqrt_req = 1'b1;
    run_op("rr1", 1'b0, 27, -1, 0, 1'b0);
    idle_gap("rr1");
    run_op("rr2", 1'b1, 26, -1, 0, 1'b0);
    idle_gap("rr2");
    run_op("rr3", 1'b0, 27, -1, 0, 1'b0);
    bus.div_req  = 1'b0;
    bus.sqrt_req = 1'b0;
    idle_gap("rr3");

    // single-step sqrt on the SQRT_ITER=1 instance
    bus1.sqrt_req = 1'b1;
    tick();
    check("it1 load", {bus1.sqrt_gnt, bus1.busy, bus1.owner, bus1.step}, 4'b1110);
    bus1.sqrt_req = 1'b0;
    tick();
    check("it1 step",  {bus1.step, bus1.first, bus1.last, bus1.done}, 4'b1110);
    check("it1 count", bus1.count, 0);
    tick();
    check("it1 done",  {bus1.step, bus1.done, bus1.sqrt_gnt}, 3'b011);
    tick();
    check("it1 idle",  {bus1.busy, bus1.done, bus1.sqrt_gnt}, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
